mgr_array_sync_barrier: RTL
===========================

Name: mgr_array_sync_barrier

Overview:
- Parametrised barrier-synchronisation controller for the manager array; replaces the fixed per-manager ready/complete/synchronized tie-offs.
- Collects per-manager arrival pulses and releases all participating managers together.
- Supports a runtime participant mask, epoch counting, and timeout with missing-manager capture.
- Sits at array level beside the stack-bus upstream connections; one instance serves all NUM_MGR managers.

Parameters:
- NUM_MGR, 64, number of managers served (≥1)
- TIMEOUT_W, 16, timeout counter width
- EPOCH_W, 4, barrier epoch counter width

Ports:
- clk  input  1  system clock
- reset_poweron  input  1  synchronous active-high reset
- cfg__sync__participantMask  input  NUM_MGR  participant mask to load
- cfg__sync__maskValid  input  1  load-mask pulse
- cfg__sync__timeout  input  TIMEOUT_W  gather timeout in cycles; 0 = disabled
- cfg__sync__clear  input  1  pulse; exits ERROR
- mgr__sys__arrive  input  NUM_MGR  per-manager one-cycle arrival pulse
- sys__mgr__thisSynchronized  output  NUM_MGR  one-cycle release pulse per participant
- sys__mgr__ready  output  NUM_MGR  level: manager may arrive
- sys__sync__epoch  output  EPOCH_W  completed-barrier count
- sys__sync__busy  output  1  state is GATHER
- sys__sync__timeoutErr  output  1  sticky timeout flag
- sys__sync__missing  output  NUM_MGR  participants absent at timeout
- sys__sync__cfgRejected  output  1  one-cycle pulse: mask load refused

Behaviour:
- Single clock domain; clk with synchronous active-high reset_poweron.
- Reset:
  - state = IDLE, mask = all ones, arrived = 0, epoch = 0, timer = 0.
  - All outputs 0 except sys__mgr__ready, which is all ones in the first cycle after reset.
- Internal signals:
  - effArrive = mgr__sys__arrive & mask; non-participant pulses are ignored.
  - allDone = &(arrived | effArrive | ~mask), evaluated combinationally.
- FSM states: IDLE, GATHER, ERROR. All outputs are registered.
- Release (from IDLE or GATHER, when mask != 0 and allDone):
  - Takes effect on the next edge.
  - thisSynchronized <= mask for exactly one cycle, arrived <= 0, epoch <= epoch+1 (wraps 2^EPOCH_W-1 -> 0), state <= IDLE.
  - Latency: last arrival in cycle t, release pulse visible in cycle t+1.
- IDLE:
  - Any effArrive without allDone -> GATHER; arrived |= effArrive; timer <= 0.
  - mask == 0: the block stays IDLE permanently, with no releases and no errors.
- GATHER:
  - arrived |= effArrive each cycle; duplicate arrivals are idempotent.
  - timer increments each cycle.
  - When timeout != 0, timer == timeout-1 and !allDone: state <= ERROR, timeoutErr <= 1, missing <= mask & ~(arrived | effArrive).
  - If completion and timeout coincide in the same cycle, completion wins.
- ERROR:
  - Arrivals are ignored and ready = 0.
  - cfg__sync__clear -> IDLE, arrived = 0, timeoutErr = 0, missing = 0; epoch is unchanged.
  - clear pulses in other states have no effect.
- sys__mgr__ready[i] = (state != ERROR) & mask[i] & ~arrived_next[i].
- Mask load:
  - Accepted only in IDLE with arrived == 0; the new mask applies from the next cycle.
  - Otherwise the load is dropped and cfgRejected pulses for one cycle.
- Reset mid-GATHER or mid-ERROR: returns to reset values on the next edge, with no release pulse.
- NUM_MGR = 1: every arrival releases in the next cycle; GATHER is never entered.

Decomposition:
- Shared package mgr_sync_pkg holds:
  - state enumeration (IDLE = 2'd0, GATHER = 2'd1, ERROR = 2'd2)
  - width constants MGR_SYNC_EPOCH_RANGE and MGR_SYNC_TIMEOUT_RANGE
  - default mask constant
- One sub-module, mgr_sync_timer: loadable up-counter with enable, clear and terminal-count compare against cfg timeout (0 disables).

Test Plan:
1. NUM_MGR=4, mask=4'b1111, arrivals for mgr 0,1,2 in cycles 1,3,5 and mgr 3 in cycle 8 -> thisSynchronized=4'b1111 in cycle 9 only, epoch=1, busy high in cycles 2–8.
2. mask=4'b0101 loaded in IDLE; arrivals on mgr 1,3 ignored; mgr 0 in cycle 2, mgr 2 in cycle 4 -> release 4'b0101 in cycle 5; ready[1], ready[3] stay 0.
3. timeout=10, mgr 0,2 arrive in cycle 1, none after -> ERROR entered 10 cycles after the first arrival; timeoutErr=1, missing=4'b1010, ready=0; clear -> IDLE, epoch unchanged.
4. Last arrival lands on the timeout terminal cycle -> release pulse, no timeoutErr.
5. Mask load during GATHER -> cfgRejected pulse, old mask retained; 16 consecutive barriers with EPOCH_W=4 -> epoch wraps to 0.
6. reset_poweron asserted mid-GATHER with 2 of 4 arrived -> next cycle: arrived=0, epoch=0, mask all ones, no release pulse.

Source files
------------

// File: rtl/mgr_sync_pkg.sv
// Shared types and constants for the manager-array barrier synchroniser.
`default_nettype none

package mgr_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_ERROR  = 2'd2
  } sync_state_t;

  localparam int MGR_SYNC_EPOCH_RANGE   = 4;
  localparam int MGR_SYNC_TIMEOUT_RANGE = 16;

  // Replicated across NUM_MGR: every manager participates out of reset.
  localparam logic MGR_SYNC_DEFAULT_MASK_BIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mgr_sync_timer.sv
// Loadable gather timer; terminal flags the last cycle before the timeout (timeout 0 disables).
`default_nettype none

module mgr_sync_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic [WIDTH-1:0] timeout,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = (timeout != '0) && (count == (timeout - WIDTH'(1)));

endmodule

`default_nettype wire

// File: rtl/mgr_array_sync_barrier.sv
// Barrier controller: gathers per-manager arrivals and releases all participants together,
// with runtime participant mask, epoch count and gather timeout.
`default_nettype none

module mgr_array_sync_barrier
  import mgr_sync_pkg::*;
#(
  parameter int NUM_MGR   = 64,
  parameter int TIMEOUT_W = MGR_SYNC_TIMEOUT_RANGE,
  parameter int EPOCH_W   = MGR_SYNC_EPOCH_RANGE
) (
  input  logic                 clk,
  input  logic                 reset_poweron,
  input  logic [NUM_MGR-1:0]   cfg__sync__participantMask,
  input  logic                 cfg__sync__maskValid,
  input  logic [TIMEOUT_W-1:0] cfg__sync__timeout,
  input  logic                 cfg__sync__clear,
  input  logic [NUM_MGR-1:0]   mgr__sys__arrive,
  output logic [NUM_MGR-1:0]   sys__mgr__thisSynchronized,
  output logic [NUM_MGR-1:0]   sys__mgr__ready,
  output logic [EPOCH_W-1:0]   sys__sync__epoch,
  output logic                 sys__sync__busy,
  output logic                 sys__sync__timeoutErr,
  output logic [NUM_MGR-1:0]   sys__sync__missing,
  output logic                 sys__sync__cfgRejected
);

  sync_state_t        state, state_n;
  logic [NUM_MGR-1:0] mask, mask_n;
  logic [NUM_MGR-1:0] arrived, arrived_n;
  logic [NUM_MGR-1:0] eff_arrive;
  logic [NUM_MGR-1:0] sync_n, ready_n, missing_n;
  logic [EPOCH_W-1:0] epoch_n;
  logic               err_n, reject_n;
  logic               all_done, release_go, mask_accept, timer_term;

  assign eff_arrive  = mgr__sys__arrive & mask;
  assign all_done    = &(arrived | eff_arrive | ~mask);
  assign release_go  = (state != ST_ERROR) && (mask != '0) && all_done;
  assign mask_accept = (state == ST_IDLE) && (arrived == '0);

  // Held at zero outside GATHER so the count starts fresh on every gather.
  mgr_sync_timer #(
    .WIDTH(TIMEOUT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (reset_poweron),
    .load     (state != ST_GATHER),
    .load_val ('0),
    .enable   (state == ST_GATHER),
    .timeout  (cfg__sync__timeout),
    .terminal (timer_term)
  );

  always_comb begin
    state_n   = state;
    mask_n    = mask;
    arrived_n = arrived;
    epoch_n   = sys__sync__epoch;
    err_n     = sys__sync__timeoutErr;
    missing_n = sys__sync__missing;
    sync_n    = '0;
    reject_n  = 1'b0;

    if (cfg__sync__maskValid) begin
      if (mask_accept) mask_n = cfg__sync__participantMask;
      else             reject_n = 1'b1;
    end

    case (state)
      ST_IDLE, ST_GATHER: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (release_go) begin
          sync_n    = mask;
          arrived_n = '0;
          epoch_n   = sys__sync__epoch + EPOCH_W'(1);
          state_n   = ST_IDLE;
        end else if ((state == ST_GATHER) && timer_term) begin
          state_n   = ST_ERROR;
          err_n     = 1'b1;
          missing_n = mask & ~(arrived | eff_arrive);
          arrived_n = arrived | eff_arrive;
        end else if (eff_arrive != '0) begin
          arrived_n = arrived | eff_arrive;
          state_n   = ST_GATHER;
        end
      end
      ST_ERROR: begin
        if (cfg__sync__clear) begin
          state_n   = ST_IDLE;
          arrived_n = '0;
          err_n     = 1'b0;
          missing_n = '0;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        arrived_n = '0;
      end
    endcase

    ready_n = (state_n == ST_ERROR) ? '0 : (mask_n & ~arrived_n);
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state                      <= ST_IDLE;
      mask                       <= {NUM_MGR{MGR_SYNC_DEFAULT_MASK_BIT}};
      arrived                    <= '0;
      sys__sync__epoch           <= '0;
      sys__mgr__thisSynchronized <= '0;
      sys__mgr__ready            <= {NUM_MGR{MGR_SYNC_DEFAULT_MASK_BIT}};
      sys__sync__busy            <= 1'b0;
      sys__sync__timeoutErr      <= 1'b0;
      sys__sync__missing         <= '0;
      sys__sync__cfgRejected     <= 1'b0;
    end else begin
      state                      <= state_n;
      mask                       <= mask_n;
      arrived                    <= arrived_n;
      sys__sync__epoch           <= epoch_n;
      sys__mgr__thisSynchronized <= sync_n;
      sys__mgr__ready            <= ready_n;
      sys__sync__busy            <= (state_n == ST_GATHER);
      sys__sync__timeoutErr      <= err_n;
      sys__sync__missing         <= missing_n;
      sys__sync__cfgRejected     <= reject_n;
    end
  end

endmodule

`default_nettype wire
